// File: rtl/mips_decls_p.sv
// Shared declarations for the multicycle MIPS: core control states and
// the memory arbiter states plus its latency-counter helpers.
package mips_decls_p;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX
  } state_t;

  typedef enum logic [1:0] {
    ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP
  } arb_state_t;

  localparam int ARB_CNT_W = 4;

  function automatic logic [ARB_CNT_W-1:0] arb_lat_load(input int lat);
    return ARB_CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker; on a tie the port that did not
// win last time is chosen.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req0 | req1;
    winner = 1'b0;
    if (req0 && req1) winner = ~last_gnt;
    else if (req1)    winner = 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of the unified MIPS memory.
//   state     | meaning
//   ARB_IDLE  | waiting for a request; grant and register the winner
//   ARB_ISSUE | one-cycle memory strobe, latency counter loaded
//   ARB_WAIT  | counting down the memory latency, rdata captured at zero
//   ARB_RESP  | one-cycle ack to the granted port
module mem_arbiter
  import mips_decls_p::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ARB_CNT_W-1:0] LAT_LOAD = arb_lat_load(MEM_LAT);

  arb_state_t             state, state_nx;
  logic                   gnt;
  logic                   last_gnt;
  logic                   we_r;
  logic [ADDR_W-1:0]      addr_r;
  logic [DATA_W-1:0]      wdata_r;
  logic [ARB_CNT_W-1:0]   cnt;
  logic                   pick_valid;
  logic                   pick_winner;

  rr_pick2 u_pick (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt),
    .valid    (pick_valid),
    .winner   (pick_winner)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nx;
  end

  // WAIT is always visited so the latched read data is ready in the ack cycle.
  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    ack0     = 1'b0;
    ack1     = 1'b0;
    case (state)
      ARB_IDLE: begin
        busy = 1'b0;
        if (pick_valid) state_nx = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        mem_en   = 1'b1;
        mem_we   = we_r;
        state_nx = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (cnt == '0) state_nx = ARB_RESP;
      end
      ARB_RESP: begin
        ack0     = ~gnt;
        ack1     = gnt;
        state_nx = ARB_IDLE;
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      we_r     <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= '0;
      cnt      <= '0;
      rdata    <= '0;
    end else begin
      if (state == ARB_IDLE && pick_valid) begin
        gnt      <= pick_winner;
        last_gnt <= pick_winner;
        we_r     <= pick_winner ? we1    : we0;
        addr_r   <= pick_winner ? addr1  : addr0;
        wdata_r  <= pick_winner ? wdata1 : wdata0;
      end
      if (state == ARB_ISSUE)
        cnt <= LAT_LOAD;
      else if (state == ARB_WAIT && cnt != '0)
        cnt <= cnt - 1'b1;
      if (state == ARB_WAIT && cnt == '0)
        rdata <= mem_rdata;
    end
  end

  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench: one arbiter with MEM_LAT=1 and one with MEM_LAT=3,
// each in front of a small latency-pipelined memory model.
module tb_mem_arbiter;

  typedef struct packed {
    logic        port;
    logic        chk;
    logic [31:0] data;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, req0_a, req1_a, we0_a, we1_a;
  logic [31:0] addr0_a, addr1_a, wdata0_a, wdata1_a;
  logic        ack0_a, ack1_a, busy_a, mem_en_a, mem_we_a;
  logic [31:0] rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;

  logic        reset_b, req0_b, req1_b, we0_b, we1_b;
  logic [31:0] addr0_b, addr1_b, wdata0_b, wdata1_b;
  logic        ack0_b, ack1_b, busy_b, mem_en_b, mem_we_b;
  logic [31:0] rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_a (
    .clk(clk), .reset(reset_a),
    .req0(req0_a), .req1(req1_a), .we0(we0_a), .we1(we1_a),
    .addr0(addr0_a), .addr1(addr1_a), .wdata0(wdata0_a), .wdata1(wdata1_a),
    .ack0(ack0_a), .ack1(ack1_a), .rdata(rdata_a), .busy(busy_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut_b (
    .clk(clk), .reset(reset_b),
    .req0(req0_b), .req1(req1_b), .we0(we0_b), .we1(we1_b),
    .addr0(addr0_b), .addr1(addr1_b), .wdata0(wdata0_b), .wdata1(wdata1_b),
    .ack0(ack0_b), .ack1(ack1_b), .rdata(rdata_b), .busy(busy_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  function automatic logic [31:0] pat(input int a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  // Memory models: read data appears MEM_LAT cycles after the strobe cycle;
  // non-strobe cycles feed a poison word so a mistimed capture is visible.
  logic [31:0] mem_a [64];
  logic [31:0] pipe_a [1];
  logic [31:0] mem_b [64];
  logic [31:0] pipe_b [3];

  always @(posedge clk) begin
    if (reset_a) begin
      for (int i = 0; i < 64; i++) mem_a[i] <= pat(i * 4);
      mem_a[4] <= 32'h2002_0005;
    end else if (mem_en_a && mem_we_a) begin
      mem_a[mem_addr_a[7:2]] <= mem_wdata_a;
    end
    pipe_a[0] <= mem_en_a ? mem_a[mem_addr_a[7:2]] : 32'hBAD0_BAD0;
  end
  assign mem_rdata_a = pipe_a[0];

  always @(posedge clk) begin
    if (reset_b) begin
      for (int i = 0; i < 64; i++) mem_b[i] <= pat(i * 4);
    end else if (mem_en_b && mem_we_b) begin
      mem_b[mem_addr_b[7:2]] <= mem_wdata_b;
    end
    pipe_b[0] <= mem_en_b ? mem_b[mem_addr_b[7:2]] : 32'hBAD0_BAD0;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign mem_rdata_b = pipe_b[2];

  sb_t qa[$];
  sb_t qb[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  n;
  int  ack_cyc [4];

  function automatic sb_t mk(input logic port, input logic chk, input logic [31:0] data);
    sb_t e;
    e.port = port;
    e.chk  = chk;
    e.data = data;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample #1 after the edge, and retire any ack against
  // the scoreboard of that arbiter.
  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    if (ack0_a || ack1_a) begin
      if (qa.size() == 0) check("a_unexpected_ack", {30'b0, ack1_a, ack0_a}, 32'd0);
      else begin
        e = qa.pop_front();
        check("a_ack_both", {31'b0, ack0_a & ack1_a}, 32'd0);
        check("a_ack_port", {31'b0, ack1_a}, {31'b0, e.port});
        if (e.chk) check("a_rdata", rdata_a, e.data);
      end
    end
    if (ack0_b || ack1_b) begin
      if (qb.size() == 0) check("b_unexpected_ack", {30'b0, ack1_b, ack0_b}, 32'd0);
      else begin
        e = qb.pop_front();
        check("b_ack_both", {31'b0, ack0_b & ack1_b}, 32'd0);
        check("b_ack_port", {31'b0, ack1_b}, {31'b0, e.port});
        if (e.chk) check("b_rdata", rdata_b, e.data);
      end
    end
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic wait_ack_b(output int lat);
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (ack0_b || ack1_b) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    reset_a = 1'b1; req0_a = 1'b0; req1_a = 1'b0; we0_a = 1'b0; we1_a = 1'b0;
    addr0_a = '0; addr1_a = '0; wdata0_a = '0; wdata1_a = '0;
    reset_b = 1'b1; req0_b = 1'b0; req1_b = 1'b0; we0_b = 1'b0; we1_b = 1'b0;
    addr0_b = '0; addr1_b = '0; wdata0_b = '0; wdata1_b = '0;
    ticks(2);
    reset_a = 1'b0;
    reset_b = 1'b0;

    check("a_rst_ack", {30'b0, ack1_a, ack0_a}, 32'd0);
    check("a_rst_rdata", rdata_a, 32'd0);
    check("a_rst_busy", {31'b0, busy_a}, 32'd0);
    check("a_rst_mem_en", {30'b0, mem_en_a, mem_we_a}, 32'd0);
    check("a_rst_mem_addr", mem_addr_a, 32'd0);
    check("a_rst_mem_wdata", mem_wdata_a, 32'd0);
    check("b_rst_rdata", rdata_b, 32'd0);
    check("b_rst_busy", {31'b0, busy_b}, 32'd0);

    // single read on port 0
    req0_a = 1'b1; we0_a = 1'b0; addr0_a = 32'h0000_0010;
    qa.push_back(mk(1'b0, 1'b1, 32'h2002_0005));
    tick();
    check("a_rd_c1_mem_en", {31'b0, mem_en_a}, 32'd1);
    check("a_rd_c1_mem_addr", mem_addr_a, 32'h10);
    check("a_rd_c1_busy", {31'b0, busy_a}, 32'd1);
    tick();
    check("a_rd_c2_mem_en", {31'b0, mem_en_a}, 32'd0);
    check("a_rd_c2_ack", {30'b0, ack1_a, ack0_a}, 32'd0);
    tick();
    check("a_rd_c3_ack0", {30'b0, ack1_a, ack0_a}, 32'd1);
    req0_a = 1'b0;
    tick();
    check("a_rd_c4_idle", {29'b0, busy_a, ack1_a, ack0_a}, 32'd0);

    // write on port 1, then read it back on port 0
    req1_a = 1'b1; we1_a = 1'b1; addr1_a = 32'h54; wdata1_a = 32'h0000_0007;
    qa.push_back(mk(1'b1, 1'b0, 32'd0));
    tick();
    check("a_wr_c1_mem_en_we", {30'b0, mem_en_a, mem_we_a}, 32'd3);
    check("a_wr_c1_mem_addr", mem_addr_a, 32'h54);
    check("a_wr_c1_mem_wdata", mem_wdata_a, 32'h7);
    tick();
    check("a_wr_c2_mem_we", {31'b0, mem_we_a}, 32'd0);
    tick();
    check("a_wr_c3_ack1", {30'b0, ack1_a, ack0_a}, 32'd2);
    req1_a = 1'b0; we1_a = 1'b0;
    tick();
    req0_a = 1'b1; we0_a = 1'b0; addr0_a = 32'h54;
    qa.push_back(mk(1'b0, 1'b1, 32'h0000_0007));
    tick();
    check("a_rb_c1_mem_we", {30'b0, mem_en_a, mem_we_a}, 32'd2);
    ticks(2);
    req0_a = 1'b0;
    tick();

    // continuous tie from reset: strict alternation starting at port 0
    reset_a = 1'b1;
    ticks(2);
    reset_a = 1'b0;
    req0_a = 1'b1; addr0_a = 32'h20;
    req1_a = 1'b1; addr1_a = 32'h30; we1_a = 1'b0;
    qa.push_back(mk(1'b0, 1'b1, pat(32'h20)));
    qa.push_back(mk(1'b1, 1'b1, pat(32'h30)));
    qa.push_back(mk(1'b0, 1'b1, pat(32'h20)));
    qa.push_back(mk(1'b1, 1'b1, pat(32'h30)));
    for (int k = 0; k < 4; k++) ack_cyc[k] = -1;
    n = 0;
    for (int c = 1; c <= 24 && n < 4; c++) begin
      tick();
      if (ack0_a || ack1_a) begin
        ack_cyc[n] = c;
        n++;
      end
    end
    req0_a = 1'b0;
    req1_a = 1'b0;
    for (int k = 0; k < 4; k++)
      check($sformatf("a_rr_ack_cycle%0d", k), ack_cyc[k], 32'(3 + 4 * k));
    tick();

    // port 0 drops req right after the grant of a write
    req0_a = 1'b1; we0_a = 1'b1; addr0_a = 32'h40; wdata0_a = 32'h1234_5678;
    qa.push_back(mk(1'b0, 1'b0, 32'd0));
    tick();
    check("a_drop_c1_mem_en_we", {30'b0, mem_en_a, mem_we_a}, 32'd3);
    req0_a = 1'b0; we0_a = 1'b0;
    tick();
    check("a_drop_c2_ack", {30'b0, ack1_a, ack0_a}, 32'd0);
    tick();
    check("a_drop_c3_ack0", {30'b0, ack1_a, ack0_a}, 32'd1);
    tick();
    check("a_drop_c4_idle", {31'b0, busy_a}, 32'd0);
    req0_a = 1'b1; addr0_a = 32'h40;
    qa.push_back(mk(1'b0, 1'b1, 32'h1234_5678));
    ticks(3);
    req0_a = 1'b0;
    tick();

    // MEM_LAT=3 read on port 1
    req1_b = 1'b1; we1_b = 1'b0; addr1_b = 32'h08;
    qb.push_back(mk(1'b1, 1'b1, pat(32'h08)));
    for (int c = 1; c <= 6; c++) begin
      tick();
      check($sformatf("b_lat3_busy_c%0d", c), {31'b0, busy_b}, {31'b0, c <= 5});
      check($sformatf("b_lat3_mem_en_c%0d", c), {31'b0, mem_en_b}, {31'b0, c == 1});
      check($sformatf("b_lat3_ack1_c%0d", c), {31'b0, ack1_b}, {31'b0, c == 5});
      if (c == 5) req1_b = 1'b0;
    end

    // reset while waiting on memory: no ack, and port 0 wins the next tie
    req0_b = 1'b1; we0_b = 1'b0; addr0_b = 32'h0C;
    ticks(2);
    reset_b = 1'b1;
    req1_b = 1'b1; addr1_b = 32'h18;
    tick();
    check("b_rst_wait_mem_en", {31'b0, mem_en_b}, 32'd0);
    check("b_rst_wait_busy", {31'b0, busy_b}, 32'd0);
    check("b_rst_wait_rdata", rdata_b, 32'd0);
    check("b_rst_wait_ack", {30'b0, ack1_b, ack0_b}, 32'd0);
    check("b_rst_wait_mem_addr", mem_addr_b, 32'd0);
    reset_b = 1'b0;
    qb.push_back(mk(1'b0, 1'b1, pat(32'h0C)));
    wait_ack_b(n);
    check("b_post_rst_ack_lat", n, 32'd5);
    req0_b = 1'b0;
    qb.push_back(mk(1'b1, 1'b1, pat(32'h18)));
    wait_ack_b(n);
    check("b_second_ack_lat", n, 32'd6);
    req1_b = 1'b0;
    ticks(2);

    check("a_sb_drained", qa.size(), 32'd0);
    check("b_sb_drained", qb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
